line_tx_scheduler: RTL

//  Round-robin scheduler that shares one line-code transmitter (NRZ / Manchester / PAM4 encoder) between N_REQ frame sources.
//  It captures one parallel frame from the winning source and selects the encoder mode.
//  It then sequences a preamble, serialises the payload at the per-mode symbol rate, and enforces an inter-frame gap.
//  It sits between the frame sources and the line-code converter datapath.

---
 rtl/line_tx_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/line_tx_scheduler.sv
// Round-robin scheduler feeding one line-code encoder (NRZ / Manchester / PAM4) from N_REQ frame sources.
// Latency: a request seen in IDLE at edge e gives o_grant and the first preamble symbol in cycle e+1.
//   The first data symbol follows in cycle e+1+PRE_LEN.
// Backpressure: none downstream. Sources hold i_req until o_done/o_err, and losing sources wait in place.
//
// Ports:
//   i_clk, i_reset_n         clock, synchronous active-low reset
//   i_req/i_data/i_mode      per-source request, frame payload [k*W +: W], mode [2k +: 2]
//   o_grant/o_done/o_err     one-hot single-cycle pulses identifying the source
//   o_enc_sel/o_sym/o_half   encoder mode, symbol, Manchester half-bit phase
//   o_valid/o_busy           symbol qualifier, scheduler not idle
module line_tx_scheduler #(
  parameter int N_REQ    = 3,
  parameter int W        = 8,
  parameter int PRE_LEN  = 4,
  parameter int GAP_CLKS = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_data,
  input  logic [N_REQ*2-1:0] i_mode,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_done,
  output logic [N_REQ-1:0]   o_err,
  output logic [1:0]         o_enc_sel,
  output logic [1:0]         o_sym,
  output logic               o_half,
  output logic               o_valid,
  output logic               o_busy
);

  localparam int MAX_A = (2 * W > PRE_LEN) ? 2 * W : PRE_LEN;
  localparam int MAXC  = (MAX_A > GAP_CLKS) ? MAX_A : GAP_CLKS;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int IW    = $clog2(N_REQ);

  localparam logic [1:0] M_NRZ = 2'd0;
  localparam logic [1:0] M_MAN = 2'd1;
  localparam logic [1:0] M_PAM = 2'd2;
  localparam logic [1:0] M_ILL = 2'd3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  state_t           state, nxt_state;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic [W-1:0]     sh, nxt_sh;
  logic [1:0]       mode_r, nxt_mode;
  logic [IW-1:0]    rr, nxt_rr;
  logic [N_REQ-1:0] idx_oh, nxt_idx_oh;

  logic             found;
  logic [IW-1:0]    pick, scan;
  logic [N_REQ-1:0] pick_oh;
  logic [1:0]       sel_mode;
  logic [W-1:0]     sel_data;
  logic [CW-1:0]    data_last;

  logic [N_REQ-1:0] grant_n, done_n, err_n;
  logic [1:0]       sym_n, enc_n;
  logic             half_n, valid_n;

  // Round-robin search starting at rr, wrapping; first requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = IW'((int'(rr) + i) % N_REQ);
      if (!found && i_req[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
    pick_oh  = '0;
    sel_mode = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == IW'(k)) begin
        pick_oh[k] = 1'b1;
        sel_mode   = i_mode[2*k +: 2];
        sel_data   = i_data[k*W +: W];
      end
    end
  end

  always_comb begin
    case (mode_r)
      M_MAN:   data_last = CW'(2 * W - 1);
      M_PAM:   data_last = CW'(W / 2 - 1);
      default: data_last = CW'(W - 1);
    endcase
  end

  // Next-state logic.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_sh     = sh;
    nxt_mode   = mode_r;
    nxt_rr     = rr;
    nxt_idx_oh = idx_oh;
    grant_n    = '0;
    done_n     = '0;
    err_n      = '0;
    case (state)
      IDLE: begin
        if (found) begin
          nxt_idx_oh = pick_oh;
          nxt_rr     = (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          nxt_cnt    = '0;
          nxt_mode   = sel_mode;
          nxt_sh     = sel_data;
          if (sel_mode == M_ILL) begin
            nxt_state = GAP;
            err_n     = pick_oh;
          end else begin
            nxt_state = PRE;
            grant_n   = pick_oh;
          end
        end
      end
      PRE: begin
        if (cnt == CW'(PRE_LEN - 1)) begin
          nxt_state = DATA;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == data_last) begin
          nxt_state = GAP;
          nxt_cnt   = '0;
          done_n    = idx_oh;
        end else begin
          nxt_cnt = cnt + 1'b1;
          case (mode_r)
            M_PAM:   nxt_sh = sh << 2;
            // Manchester holds each bit across both halves.
            M_MAN:   nxt_sh = cnt[0] ? (sh << 1) : sh;
            default: nxt_sh = sh << 1;
          endcase
        end
      end
      default: begin
        if (cnt == CW'(GAP_CLKS - 1)) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
    endcase
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    valid_n = (nxt_state == PRE) || (nxt_state == DATA);
    enc_n   = valid_n ? nxt_mode : 2'b00;
    sym_n   = 2'b00;
    half_n  = 1'b0;
    if (nxt_state == PRE) begin
      sym_n = nxt_cnt[0] ? 2'b00 : 2'b11;
    end else if (nxt_state == DATA) begin
      if (nxt_mode == M_PAM) begin
        sym_n = nxt_sh[W-1 -: 2];
      end else begin
        sym_n = {1'b0, nxt_sh[W-1]};
      end
      half_n = (nxt_mode == M_MAN) && nxt_cnt[0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      mode_r    <= '0;
      rr        <= '0;
      idx_oh    <= '0;
      o_grant   <= '0;
      o_done    <= '0;
      o_err     <= '0;
      o_enc_sel <= '0;
      o_sym     <= '0;
      o_half    <= 1'b0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      sh        <= nxt_sh;
      mode_r    <= nxt_mode;
      rr        <= nxt_rr;
      idx_oh    <= nxt_idx_oh;
      o_grant   <= grant_n;
      o_done    <= done_n;
      o_err     <= err_n;
      o_enc_sel <= enc_n;
      o_sym     <= sym_n;
      o_half    <= half_n;
      o_valid   <= valid_n;
      o_busy    <= (nxt_state != IDLE);
    end
  end

endmodule
